chain_capture: RTL and testbench
================================

# chain_capture

Downstream capture stage for the 32-bit rotate-chain memory output. On a start pulse it samples a programmable number of consecutive chain words into a local FIFO, keeps a running XOR checksum, and drains the words to a consumer over a valid/ready handshake. It gives the test harness a back-pressurable, bounded window into the free-running chain output.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..64.
- `LEN_W`, 5: width of `cfg_len`; must satisfy 2^LEN_W > DEPTH.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `data_in`  in  32: chain output word, new value every cycle.
- `start`  in  1: capture request, sampled only in IDLE.
- `cfg_len`  in  LEN_W: words to capture, latched on accepted start.
- `out_data`  out  32: FIFO head word.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts `out_data` when high with `out_valid`.
- `busy`  out  1: high in CAPTURE and DRAIN.
- `done`  out  1: one-cycle pulse at end of drain.
- `checksum`  out  32: XOR of all words written this window.
- `overflow`  out  1: sticky; a word was dropped because the FIFO was full.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: `start`=1 and `cfg_len`≠0 is an accepted start. It latches `cfg_len` into `remain`, clears `checksum` and `overflow`, and moves to CAPTURE. `start` with `cfg_len`=0 is ignored. `cfg_len` > DEPTH is legal; excess words may overflow.
- CAPTURE: every cycle, one `data_in` word is presented for push and `remain` decrements.
  - When `remain` reaches 0 after the decrement, the state moves to DRAIN.
  - Words are taken on the cycles after start, never on the start cycle.
- Push rule: the word is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the word is dropped and `overflow` is set to 1.
- `checksum` ^= word only for words that are written.
- DRAIN: no pushes. When the FIFO is empty, or becomes empty through a pop this cycle, the state moves to IDLE and `done` pulses on that transition edge.
- `start` in CAPTURE or DRAIN is ignored; no queuing.
- FIFO is show-ahead: `out_data` = head when `out_valid`=1, and is 0 when empty.
- Pop occurs when `out_valid` && `out_ready`. Pops are allowed in any state, including IDLE with leftover data (not possible in normal flow).
- Reset mid-operation: the FIFO empties, the state returns to IDLE, and the captured window is lost.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `checksum`=0, `overflow`=0. State is IDLE and FIFO pointers are 0.
- Start accepted at edge T: `busy`=1 from T. Words are taken at edges T+1 .. T+N.
- First `out_valid` is seen after edge T+1, so the push-to-valid latency is 1 cycle.
- With `out_ready` held at 1 and N ≤ DEPTH, the last pop occurs after edge T+N+1. `done`=1 for one cycle and `busy`=0 follow the DRAIN→IDLE edge.
- `checksum` and `overflow` are stable from the `done` pulse until the next accepted start.
- Occupancy counter width: clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Structure
- `chain_capture_pkg` holds:
  - the state enum `cap_state_t` {IDLE, CAPTURE, DRAIN};
  - the `DATA_W`=32 constant;
  - the default DEPTH constant.
- One sub-module, `chain_fifo`: a synchronous show-ahead FIFO with DEPTH/width parameters. It provides push, pop, full, empty and count, and allows a simultaneous push and pop when full.
- The top level contains the FSM, the `remain` counter, the checksum and the overflow logic.

## Test plan
- Basic window: `cfg_len`=4, `out_ready`=1, `data_in`=1,2,3,4 on the capture cycles.
  - Required: outputs 1,2,3,4 in order, `checksum`=0x4, `done` pulses once, `overflow`=0.
- Back-pressure overflow: DEPTH=16, `cfg_len`=20, `out_ready`=0.
  - Required: 16 words stored, `overflow`=1, checksum covers only the first 16 words.
  - Then raise `out_ready`: 16 pops, then `done`.
- Full with simultaneous pop: FIFO full in CAPTURE, `out_ready`=1.
  - Required: every word is written, no overflow, occupancy stays at 16.
- Ignored starts:
  - `start` with `cfg_len`=0 leaves `busy`=0.
  - `start` pulsed mid-CAPTURE does not alter `remain`, and the window length stays as latched.
- Reset mid-CAPTURE with the FIFO holding 5 words:
  - Required: `out_valid`=0, `checksum`=0, `busy`=0 immediately on `rst_n` low.
  - After reset release, a fresh `cfg_len`=2 window works.
- Checksum clear: run a second window `cfg_len`=1 with `data_in`=0xDEADBEEF.
  - Required: `checksum`=0xDEADBEEF, with no residue from the previous window.

Source files
------------

// File: rtl/chain_capture_pkg.sv
// Shared types and constants for the chain capture stage.
package chain_capture_pkg;

    localparam int DATA_W        = 32;
    localparam int DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/chain_fifo.sv
// Synchronous show-ahead FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle, so occupancy holds steady under full throughput.
module chain_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the data array has no reset; validity is tracked by count, so
    // clearing it would only add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/chain_capture.sv
// Capture stage: samples cfg_len consecutive chain words after a start pulse,
// buffers them in a FIFO with a running XOR checksum, and drains them to a
// valid/ready consumer.
module chain_capture
    import chain_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LEN_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [LEN_W-1:0]  remain_q;
    logic              start_ok;
    logic              done_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              capturing;
    logic              pop_fire;
    logic              write_ok;
    logic              drop;

    assign capturing = (state_q == CAPTURE);
    assign out_valid = !fifo_empty;
    assign pop_fire  = out_valid && out_ready;
    assign write_ok  = capturing && (!fifo_full || pop_fire);
    assign drop      = capturing && fifo_full && !pop_fire;
    assign busy      = (state_q != IDLE);

    chain_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capturing),
        .push_data (data_in),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic, start acceptance and end-of-drain detection.
    // NOTE: every output of this block is defaulted first so no path through
    // the case leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (cfg_len != '0)) begin
                    start_ok = 1'b1;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                // remain is the count before this cycle's decrement.
                if (remain_q == LEN_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty || (fifo_count == CNT_W'(1) && pop_fire)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remaining-word counter: loaded on accepted start, counts down in CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         remain_q <= '0;
        else if (start_ok)  remain_q <= cfg_len;
        else if (capturing) remain_q <= remain_q - LEN_W'(1);
    end

    // Window checksum over words actually written into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (write_ok) checksum <= checksum ^ data_in;
    end

    // Sticky drop flag, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        overflow <= 1'b0;
        else if (start_ok) overflow <= 1'b0;
        else if (drop)     overflow <= 1'b1;
    end

    // One-cycle done pulse following the DRAIN to IDLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= done_d;
    end

endmodule

// File: tb/tb_chain_capture.sv
// Scoreboard bench for chain_capture: a window-level reference model pushes
// expected words as they are accepted; a negedge monitor pops and compares.
module tb_chain_capture;

    localparam int DEPTH = 16;
    localparam int LEN_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       data_in = '0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;
    logic              overflow;

    chain_capture #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .start     (start),
        .cfg_len   (cfg_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: window phase, stored words, checksum, sticky flag.
    typedef enum {M_IDLE, M_CAP, M_DRAIN} m_phase_t;
    m_phase_t    m_ph = M_IDLE;
    int          m_remain = 0;
    logic [31:0] m_cks = '0;
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] mq[$];
    logic [31:0] sb[$];
    int          done_cnt = 0;
    int          pop_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic model_reset();
        m_ph = M_IDLE; m_remain = 0; m_cks = '0; m_ovf = 1'b0; m_done = 1'b0;
        mq.delete(); sb.delete();
    endtask

    task automatic model_step(logic st, logic [LEN_W-1:0] len, logic [31:0] din, logic rdy);
        bit pop = (mq.size() > 0) && rdy;
        bit wr  = 1'b0;
        m_done = 1'b0;
        case (m_ph)
            M_IDLE: if (st && len != 0) begin
                m_ph = M_CAP; m_remain = int'(len); m_cks = '0; m_ovf = 1'b0;
            end
            M_CAP: begin
                if (mq.size() < DEPTH || pop) begin wr = 1'b1; m_cks ^= din; end
                else m_ovf = 1'b1;
                m_remain--;
                if (m_remain == 0) m_ph = M_DRAIN;
            end
            M_DRAIN: if (mq.size() == 0 || (mq.size() == 1 && pop)) begin
                m_ph = M_IDLE; m_done = 1'b1; done_cnt++;
            end
            default: m_ph = M_IDLE;
        endcase
        if (pop) void'(mq.pop_front());
        if (wr) begin mq.push_back(din); sb.push_back(din); end
    endtask

    task automatic cycle(logic st, logic [LEN_W-1:0] len, logic [31:0] din, logic rdy);
        start = st; cfg_len = len; data_in = din; out_ready = rdy;
        @(posedge clk);
        model_step(st, len, din, rdy);
        #1;
    endtask

    task automatic drain(int rdy_pct);
        int n = 0;
        while (busy || out_valid) begin
            if (n >= 300) begin
                total++; bad++;
                $display("FAIL drain_timeout: busy=%0b valid=%0b after %0d cycles", busy, out_valid, n);
                break;
            end
            cycle(1'b0, '0, $urandom, ($urandom_range(99) < rdy_pct));
            n++;
        end
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("busy", busy, m_ph != M_IDLE);
            check("done", done, m_done);
            check("checksum", checksum, m_cks);
            check("overflow", overflow, m_ovf);
            check("out_valid", out_valid, sb.size() != 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_data: got %h want nothing queued", out_data);
                end else begin
                    check("out_data", out_data, sb.pop_front());
                    pop_cnt++;
                end
            end else if (!out_valid) begin
                check("out_data_empty", out_data, 32'h0);
            end
        end
    end

    initial begin
        int d0, p0;
        logic [31:0] exp_x;
        logic [31:0] w;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_checksum", checksum, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle(1'b0, '0, 32'h0, 1'b1);

        // Basic window of four words
        d0 = done_cnt; p0 = pop_cnt;
        cycle(1'b1, 5'd4, 32'h0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b0, '0, 32'(i), 1'b1);
        drain(100);
        check("basic_checksum", checksum, 32'h4);
        check("basic_overflow", overflow, 1'b0);
        check("basic_done_count", done_cnt - d0, 1);
        check("basic_pops", pop_cnt - p0, 4);

        // Back-pressure overflow: 20 words into 16 entries
        d0 = done_cnt; p0 = pop_cnt; exp_x = '0;
        cycle(1'b1, 5'd20, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            if (i < 16) exp_x ^= w;
            cycle(1'b0, '0, w, 1'b0);
        end
        check("ovf_flag", overflow, 1'b1);
        check("ovf_checksum", checksum, exp_x);
        check("ovf_stored", 32'(dut.u_fifo.count), 32'd16);
        drain(100);
        check("ovf_pops", pop_cnt - p0, 16);
        check("ovf_done_count", done_cnt - d0, 1);
        check("ovf_checksum_held", checksum, exp_x);

        // Full FIFO with simultaneous pop: every word written
        p0 = pop_cnt;
        cycle(1'b1, 5'd24, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, $urandom, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, $urandom, 1'b1);
            check("full_occupancy", 32'(dut.u_fifo.count), 32'd16);
            check("full_no_overflow", overflow, 1'b0);
        end
        drain(100);
        check("full_pops", pop_cnt - p0, 24);

        // Ignored starts
        cycle(1'b1, 5'd0, 32'h0, 1'b1);
        check("len0_busy", busy, 1'b0);
        p0 = pop_cnt;
        cycle(1'b1, 5'd6, 32'h0, 1'b1);
        cycle(1'b0, '0, $urandom, 1'b1);
        cycle(1'b0, '0, $urandom, 1'b1);
        cycle(1'b1, 5'd3, $urandom, 1'b1);
        check("mid_start_remain", 32'(dut.remain_q), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, $urandom, 1'b1);
        drain(100);
        check("mid_start_pops", pop_cnt - p0, 6);

        // Reset mid-capture with five words held
        cycle(1'b1, 5'd10, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, $urandom, 1'b0);
        check("pre_rst_count", 32'(dut.u_fifo.count), 32'd5);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_checksum", checksum, 32'h0);
        check("midrst_busy", busy, 1'b0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pop_cnt; exp_x = '0;
        cycle(1'b1, 5'd2, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_x ^= w;
            cycle(1'b0, '0, w, 1'b1);
        end
        drain(100);
        check("postrst_pops", pop_cnt - p0, 2);
        check("postrst_checksum", checksum, exp_x);

        // Checksum clears between windows
        cycle(1'b1, 5'd1, 32'h0, 1'b1);
        cycle(1'b0, '0, 32'hDEAD_BEEF, 1'b1);
        drain(100);
        check("cks_clear", checksum, 32'hDEAD_BEEF);

        // Randomised windows with random back-pressure and start noise
        for (int k = 0; k < 40; k++) begin
            int len;
            int pct;
            len = $urandom_range(1, 31);
            pct = $urandom_range(30, 100);
            d0 = done_cnt;
            cycle(1'b0, 5'($urandom), $urandom, ($urandom_range(99) < pct));
            cycle(1'b1, 5'(len), $urandom, ($urandom_range(99) < pct));
            for (int i = 0; i < len; i++)
                cycle(1'($urandom), 5'($urandom), $urandom, ($urandom_range(99) < pct));
            drain(pct);
            check("rand_done_count", done_cnt - d0, 1);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
